// File: rtl/mips_instr_encoder_if.sv
// Field-bundle input handshake and instruction-memory write bus for the encoder.
interface mips_instr_encoder_if;
  // Field bundle handshake
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [5:0]  OP;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [25:0] target;
  // Instruction memory write port
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  // Bundle source / memory sink side
  modport master (
    output in_valid, in_last, OP, funct, rs, rt, rd, shamt, imm, target,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Encoder side
  modport slave (
    input  in_valid, in_last, OP, funct, rs, rt, rd, shamt, imm, target,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// MIPS program loader: encodes R/I/J field bundles into 32-bit words and writes them to
// instruction memory at consecutive word addresses starting at BASE_ADDR.
module mips_instr_encoder #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  mips_instr_encoder_if.slave   bus,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            illegal_cnt
);

  localparam int CntW = $clog2(DEPTH + 1);

  // FLUSH is the trailing cycle in which the final word is being written
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            we_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      ill_q;

  logic            accept;
  logic            legal;
  logic            depth_hit;
  logic            restart;
  logic [31:0]     word;

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state_q == LOAD) || (state_q == FLUSH);
  assign done          = (state_q == DONE);
  assign illegal_cnt   = ill_q;

  assign accept    = bus.in_valid & bus.in_ready;
  assign depth_hit = (cnt_q == CntW'(DEPTH - 1));
  assign restart   = start && ((state_q == IDLE) || (state_q == DONE));

  // Opcode legality and field packing by instruction format
  always_comb begin
    legal = 1'b0;
    word  = {bus.OP, bus.rs, bus.rt, bus.imm};
    unique case (bus.OP)
      6'h00: begin
        legal = 1'b1;
        word  = {bus.OP, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
      end
      6'h02, 6'h03: begin
        legal = 1'b1;
        word  = {bus.OP, bus.target};
      end
      6'h08, 6'h0d, 6'h0f, 6'h0c, 6'h23, 6'h2b, 6'h04, 6'h05: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Session state transitions
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = LOAD;
      LOAD: begin
        if (accept) begin
          if (legal && (bus.in_last || depth_hit)) state_d = FLUSH;
          else if (!legal && bus.in_last)          state_d = DONE;
        end
      end
      FLUSH: state_d = DONE;
      DONE:  if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // State, write strobe, address/counter bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'd0;
      cnt_q   <= '0;
      ill_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      we_q    <= accept & legal;
      if (accept && legal) begin
        wdata_q <= word;
        cnt_q   <= cnt_q + CntW'(1);
      end
      if (accept && !legal && (ill_q != 8'hff)) ill_q <= ill_q + 8'd1;
      // Address points at the word being written during the strobe, then moves on
      if (we_q) addr_q <= addr_q + 32'd4;
      // No write can be pending in IDLE/DONE, so clearing here never races the increment
      if (restart) begin
        addr_q <= BASE_ADDR;
        cnt_q  <= '0;
        ill_q  <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder with hand-computed instruction words.
module tb_mips_instr_encoder;

  localparam logic [31:0] Base = 32'h0040_0000;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] illegal_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  mips_instr_encoder_if bus ();

  mips_instr_encoder #(
    .DEPTH     (4),
    .BASE_ADDR (Base)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance one clock; sample and drive 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] shamt, input logic [5:0] funct,
                       input logic [15:0] imm, input logic [25:0] target, input logic last);
    bus.OP = op; bus.rs = rs; bus.rt = rt; bus.rd = rd; bus.shamt = shamt;
    bus.funct = funct; bus.imm = imm; bus.target = target; bus.in_last = last;
    bus.in_valid = 1'b1;
    tick();
  endtask

  task automatic start_session();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int          nwr;
  logic [31:0] last_addr;
  logic [31:0] last_data;

  initial begin
    reset = 1'b1; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.OP = '0; bus.funct = '0; bus.rs = '0;
    bus.rt = '0; bus.rd = '0; bus.shamt = '0; bus.imm = '0; bus.target = '0;
    tick(); tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_addr", bus.mem_addr, Base);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ill", 32'(illegal_cnt), 32'd0);
    reset = 1'b0;
    tick();

    // 1: single ADDI marked last
    start_session();
    check("t1_in_ready", 32'(bus.in_ready), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    drive(6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0005, 26'd0, 1'b1);
    bus.in_valid = 1'b0;
    check("t1_we", 32'(bus.mem_we), 32'd1);
    check("t1_addr", bus.mem_addr, 32'h0040_0000);
    check("t1_wdata", bus.mem_wdata, 32'h2022_0005);
    check("t1_busy_tail", 32'(busy), 32'd1);
    check("t1_ready_tail", 32'(bus.in_ready), 32'd0);
    check("t1_done_early", 32'(done), 32'd0);
    tick();
    check("t1_we_off", 32'(bus.mem_we), 32'd0);
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_off", 32'(busy), 32'd0);

    // 2: R add then J back-to-back (also restart from DONE)
    start_session();
    check("t2_done_clr", 32'(done), 32'd0);
    drive(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 26'd0, 1'b0);
    check("t2_we0", 32'(bus.mem_we), 32'd1);
    check("t2_addr0", bus.mem_addr, 32'h0040_0000);
    check("t2_wdata0", bus.mem_wdata, 32'h0022_1820);
    drive(6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h010_0000, 1'b1);
    bus.in_valid = 1'b0;
    check("t2_we1", 32'(bus.mem_we), 32'd1);
    check("t2_addr1", bus.mem_addr, 32'h0040_0004);
    check("t2_wdata1", bus.mem_wdata, 32'h0810_0000);
    tick();
    check("t2_done", 32'(done), 32'd1);

    // 3: illegal OP between two legal words
    start_session();
    drive(6'h0d, 5'd0, 5'd1, 5'd0, 5'd0, 6'h00, 16'h1234, 26'd0, 1'b0);
    check("t3_wdata0", bus.mem_wdata, 32'h3401_1234);
    drive(6'h3f, 5'd7, 5'd7, 5'd7, 5'd7, 6'h3f, 16'hffff, 26'd0, 1'b0);
    check("t3_ill_we", 32'(bus.mem_we), 32'd0);
    check("t3_ill_cnt", 32'(illegal_cnt), 32'd1);
    drive(6'h23, 5'd29, 5'd8, 5'd0, 5'd0, 6'h00, 16'hfffc, 26'd0, 1'b1);
    bus.in_valid = 1'b0;
    check("t3_we1", 32'(bus.mem_we), 32'd1);
    check("t3_addr1", bus.mem_addr, 32'h0040_0004);
    check("t3_wdata1", bus.mem_wdata, 32'h8fa8_fffc);
    tick();
    check("t3_done", 32'(done), 32'd1);
    check("t3_ill_hold", 32'(illegal_cnt), 32'd1);

    // 4 + 6: restart clears counters, then DEPTH=4 limit with 6 bundles offered
    start_session();
    check("t6_done_clr", 32'(done), 32'd0);
    check("t6_ill_clr", 32'(illegal_cnt), 32'd0);
    check("t6_addr", bus.mem_addr, Base);
    nwr = 0; last_addr = '0; last_data = '0;
    for (int i = 0; i < 6; i++) begin
      drive(6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'(i), 26'd0, 1'b0);
      if (bus.mem_we) begin
        nwr++;
        last_addr = bus.mem_addr;
        last_data = bus.mem_wdata;
      end
    end
    bus.in_valid = 1'b0;
    tick();
    if (bus.mem_we) nwr++;
    check("t4_nwrites", 32'(nwr), 32'd4);
    check("t4_last_addr", last_addr, 32'h0040_000c);
    check("t4_last_data", last_data, 32'h2022_0003);
    check("t4_done", 32'(done), 32'd1);
    check("t4_ready", 32'(bus.in_ready), 32'd0);

    // 5: start mid-LOAD ignored; reset right after an accept drops the session
    start_session();
    drive(6'h2b, 5'd29, 5'd31, 5'd0, 5'd0, 6'h00, 16'h0010, 26'd0, 1'b0);
    check("t5_addr0", bus.mem_addr, 32'h0040_0000);
    start = 1'b1;
    drive(6'h0f, 5'd0, 5'd4, 5'd0, 5'd0, 6'h00, 16'h1001, 26'd0, 1'b0);
    start = 1'b0;
    check("t5_addr1", bus.mem_addr, 32'h0040_0004);
    check("t5_wdata1", bus.mem_wdata, 32'h3c04_1001);
    check("t5_busy", 32'(busy), 32'd1);
    drive(6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h000_0040, 1'b1);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_we", 32'(bus.mem_we), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_addr", bus.mem_addr, Base);
    tick();
    check("t5_idle_ready", 32'(bus.in_ready), 32'd0);
    check("t5_idle_done", 32'(done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
